// File: rtl/bip_exec_ctrl.sv
// Execution controller for the accumulator CPU: loads a program from a byte
// stream into instruction memory, then runs or single-steps the CPU until HALT.
module bip_exec_ctrl #(
  parameter int N_BUS  = 16,
  parameter int N_ADDR = 11,
  parameter int N_CNT  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd,
  output logic              o_cmd_ready,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  input  logic [N_BUS-1:0]  i_instr,
  output logic              o_cpu_en,
  output logic              o_cpu_clr,
  output logic              o_imem_sel,
  output logic              o_imem_we,
  output logic [N_ADDR-1:0] o_imem_addr,
  output logic [N_BUS-1:0]  o_imem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [N_CNT-1:0]  o_count
);

  typedef enum logic [1:0] {
    CMD_LOAD  = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_ABORT = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_HI,
    S_LOAD_LO,
    S_LOAD_WR,
    S_RUN,
    S_STEP,
    S_DONE
  } state_e;

  localparam logic [N_ADDR-1:0] ADDR_LAST = '1;
  localparam logic [N_CNT-1:0]  CNT_MAX   = '1;

  state_e              state, state_nxt;
  logic [N_ADDR-1:0]   addr_nxt;
  logic [N_BUS-1:0]    wdata_nxt;
  logic [N_CNT-1:0]    count_nxt;
  logic                clr_nxt;
  logic                is_load, is_run, is_step, is_abort;
  logic                instr_halt, word_halt;

  assign is_load    = i_cmd_valid && (i_cmd == CMD_LOAD);
  assign is_run     = i_cmd_valid && (i_cmd == CMD_RUN);
  assign is_step    = i_cmd_valid && (i_cmd == CMD_STEP);
  assign is_abort   = i_cmd_valid && (i_cmd == CMD_ABORT);
  assign instr_halt = (i_instr[N_BUS-1 -: 5] == 5'd0);
  assign word_halt  = (o_imem_wdata[N_BUS-1 -: 5] == 5'd0);

  // Commands are never back-pressured; unwanted ones are simply dropped.
  assign o_cmd_ready = 1'b1;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    addr_nxt  = o_imem_addr;
    wdata_nxt = o_imem_wdata;
    clr_nxt   = 1'b0;
    count_nxt = o_count;
    if (o_cpu_en && (o_count != CNT_MAX)) count_nxt = o_count + 1'b1;

    unique case (state)
      S_IDLE, S_DONE: begin
        if (is_load) begin
          state_nxt = S_LOAD_HI;
          clr_nxt   = 1'b1;
          addr_nxt  = '0;
          count_nxt = '0;
        end else if (is_abort) begin
          state_nxt = S_IDLE;
        end else if (state == S_IDLE && is_run) begin
          state_nxt = S_RUN;
        end else if (state == S_IDLE && is_step) begin
          state_nxt = S_STEP;
        end
      end
      S_LOAD_HI: begin
        if (is_abort) begin
          state_nxt = S_IDLE;
        end else if (i_byte_valid) begin
          wdata_nxt[N_BUS-1 -: 8] = i_byte;
          state_nxt               = S_LOAD_LO;
        end
      end
      S_LOAD_LO: begin
        if (is_abort) begin
          state_nxt = S_IDLE;
        end else if (i_byte_valid) begin
          wdata_nxt[7:0] = i_byte;
          state_nxt      = S_LOAD_WR;
        end
      end
      S_LOAD_WR: begin
        // The write strobe is already high this cycle; only the follow-on
        // address and state are decided here.
        if (is_abort || word_halt || (o_imem_addr == ADDR_LAST)) begin
          state_nxt = S_IDLE;
        end else begin
          addr_nxt  = o_imem_addr + 1'b1;
          state_nxt = S_LOAD_HI;
        end
      end
      S_RUN: begin
        if (is_abort)        state_nxt = S_IDLE;
        else if (instr_halt) state_nxt = S_DONE;
      end
      S_STEP: begin
        if (!is_abort && instr_halt) state_nxt = S_DONE;
        else                         state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is glitch-free and
  // lines up exactly with the state it describes.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= S_IDLE;
      o_cpu_en     <= 1'b0;
      o_cpu_clr    <= 1'b0;
      o_imem_sel   <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_byte_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_count      <= '0;
    end else begin
      state        <= state_nxt;
      o_cpu_en     <= (state_nxt == S_RUN) || (state_nxt == S_STEP);
      o_cpu_clr    <= clr_nxt;
      o_imem_sel   <= state_nxt inside {S_LOAD_HI, S_LOAD_LO, S_LOAD_WR};
      o_imem_we    <= (state_nxt == S_LOAD_WR);
      o_imem_addr  <= addr_nxt;
      o_imem_wdata <= wdata_nxt;
      o_byte_ready <= state_nxt inside {S_LOAD_HI, S_LOAD_LO};
      o_busy       <= state_nxt inside {S_LOAD_HI, S_LOAD_LO, S_LOAD_WR, S_RUN, S_STEP};
      o_done       <= (state_nxt == S_DONE);
      o_count      <= count_nxt;
    end
  end

endmodule

// File: tb/tb_bip_exec_ctrl.sv
// Bench for bip_exec_ctrl: randomized programs and run lengths checked against
// a word-level load model and an instruction-count model.
module tb_bip_exec_ctrl;

  localparam logic [1:0] LOAD = 2'b00, RUN = 2'b01, STEP = 2'b10, ABORT = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic        byte_valid = 1'b0;
  logic [7:0]  bdata = 8'h00;
  logic [15:0] instr = 16'h0800;

  logic        cmd_ready_a, byte_ready_a, cpu_en_a, cpu_clr_a, imem_sel_a, imem_we_a, busy_a, done_a;
  logic [10:0] imem_addr_a;
  logic [15:0] imem_wdata_a, count_a;
  logic        cmd_ready_b, byte_ready_b, cpu_en_b, cpu_clr_b, imem_sel_b, imem_we_b, busy_b, done_b;
  logic [1:0]  imem_addr_b;
  logic [15:0] imem_wdata_b, count_b;

  int total = 0;
  int bad = 0;
  int exp_count = 0;
  int clr_cnt = 0;
  logic [7:0]  prog[$];
  logic [31:0] exp_w[$], wlog_a[$], wlog_b[$];

  bip_exec_ctrl dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(cmd_ready_a),
    .i_byte_valid(byte_valid), .i_byte(bdata), .o_byte_ready(byte_ready_a), .i_instr(instr),
    .o_cpu_en(cpu_en_a), .o_cpu_clr(cpu_clr_a), .o_imem_sel(imem_sel_a), .o_imem_we(imem_we_a),
    .o_imem_addr(imem_addr_a), .o_imem_wdata(imem_wdata_a), .o_busy(busy_a), .o_done(done_a),
    .o_count(count_a)
  );

  bip_exec_ctrl #(.N_ADDR(2)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(cmd_ready_b),
    .i_byte_valid(byte_valid), .i_byte(bdata), .o_byte_ready(byte_ready_b), .i_instr(instr),
    .o_cpu_en(cpu_en_b), .o_cpu_clr(cpu_clr_b), .o_imem_sel(imem_sel_b), .o_imem_we(imem_we_b),
    .o_imem_addr(imem_addr_b), .o_imem_wdata(imem_wdata_b), .o_busy(busy_b), .o_done(done_b),
    .o_count(count_b)
  );

  always @(negedge clk) begin
    if (imem_we_a) wlog_a.push_back({5'b0, imem_addr_a, imem_wdata_a});
    if (imem_we_b) wlog_b.push_back({14'b0, imem_addr_b, imem_wdata_b});
    if (cpu_clr_a) clr_cnt++;
  end

  function automatic logic [15:0] nonhalt();
    logic [4:0] op = 5'($urandom_range(1, 31));
    return {op, 11'($urandom)};
  endfunction

  function automatic logic [15:0] halt_word();
    return {5'b0, 11'($urandom)};
  endfunction

  // Expected writes: consecutive byte pairs form words at addresses 0,1,...;
  // loading stops after a HALT word or after the last address.
  function automatic void model_load(input int amax);
    logic [15:0] w;
    exp_w.delete();
    for (int i = 0; 2 * i + 1 < prog.size(); i++) begin
      w = {prog[2*i], prog[2*i+1]};
      exp_w.push_back({16'(i), w});
      if (w[15:11] == 5'd0 || i == amax) break;
    end
  endfunction

  task automatic send_cmd(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd = 2'b00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    while (!byte_ready_a && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!byte_ready_a) begin
      total++; bad++;
      $display("FAIL byte_ready_timeout: got byte_ready=0 expected 1 within 20 cycles");
    end else begin
      byte_valid = 1'b1;
      bdata = b;
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic load_program();
    int g = 0;
    wlog_a.delete();
    wlog_b.delete();
    send_cmd(LOAD);
    foreach (prog[i]) send_byte(prog[i]);
    while (busy_a && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (busy_a) begin
      total++; bad++;
      $display("FAIL load_idle_timeout: got busy=1 expected 0 within 20 cycles");
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({cmd_ready_a, byte_ready_a, cpu_en_a, cpu_clr_a, imem_sel_a, imem_we_a, busy_a, done_a} !== 8'b1000_0000) begin
      bad++; $display("FAIL reset_flags_a: got %b expected 10000000",
        {cmd_ready_a, byte_ready_a, cpu_en_a, cpu_clr_a, imem_sel_a, imem_we_a, busy_a, done_a});
    end
    total++;
    if ({cmd_ready_b, byte_ready_b, cpu_en_b, cpu_clr_b, imem_sel_b, imem_we_b, busy_b, done_b} !== 8'b1000_0000) begin
      bad++; $display("FAIL reset_flags_b: got %b expected 10000000",
        {cmd_ready_b, byte_ready_b, cpu_en_b, cpu_clr_b, imem_sel_b, imem_we_b, busy_b, done_b});
    end
    total++;
    if ({imem_addr_a, imem_wdata_a, count_a, imem_addr_b, imem_wdata_b, count_b} !== 77'd0) begin
      bad++; $display("FAIL reset_values: got addr=%0d count=%0d expected 0", imem_addr_a, count_a);
    end
    #9 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy_a, done_a, cpu_en_a, count_a} !== 19'd0) begin
      bad++; $display("FAIL reset_release_idle: got busy=%b done=%b count=%0d expected 0", busy_a, done_a, count_a);
    end
  endtask

  task automatic test_load();
    int c0;
    logic [15:0] w;
    logic [31:0] last;
    for (int r = 0; r < 3; r++) begin
      if (r == 0) begin
        prog = {8'h08, 8'h05, 8'h10, 8'h03, 8'h00, 8'h00};
      end else begin
        prog.delete();
        repeat ($urandom_range(1, 5)) begin
          w = nonhalt();
          prog.push_back(w[15:8]);
          prog.push_back(w[7:0]);
        end
        w = halt_word();
        prog.push_back(w[15:8]);
        prog.push_back(w[7:0]);
      end
      model_load(2047);
      c0 = clr_cnt;
      load_program();
      exp_count = 0;
      total++;
      if (wlog_a.size() != exp_w.size()) begin
        bad++; $display("FAIL load_write_count: got %0d expected %0d", wlog_a.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < wlog_a.size(); i++) begin
        total++;
        if (wlog_a[i] !== exp_w[i]) begin
          bad++; $display("FAIL load_write[%0d]: got addr/data %h expected %h", i, wlog_a[i], exp_w[i]);
        end
      end
      last = exp_w[exp_w.size()-1];
      total++;
      if (imem_addr_a !== last[26:16]) begin
        bad++; $display("FAIL load_addr_held: got %0d expected %0d", imem_addr_a, last[26:16]);
      end
      total++;
      if ({imem_sel_a, busy_a, byte_ready_a, imem_we_a} !== 4'b0) begin
        bad++; $display("FAIL load_end_idle: got sel/busy/rdy/we=%b expected 0000",
          {imem_sel_a, busy_a, byte_ready_a, imem_we_a});
      end
      total++;
      if (clr_cnt - c0 != 1) begin
        bad++; $display("FAIL load_clr_pulses: got %0d expected 1", clr_cnt - c0);
      end
      total++;
      if (count_a !== 16'(exp_count)) begin
        bad++; $display("FAIL load_count_clear: got %0d expected %0d", count_a, exp_count);
      end
    end
  endtask

  task automatic test_run(input int n);
    logic all_en = 1'b1;
    send_cmd(ABORT);
    instr = nonhalt();
    send_cmd(RUN);
    for (int k = 1; k <= n + 1; k++) begin
      if (!cpu_en_a) all_en = 1'b0;
      instr = (k == n + 1) ? halt_word() : nonhalt();
      @(negedge clk);
    end
    exp_count += n + 1;
    total++;
    if (all_en !== 1'b1) begin
      bad++; $display("FAIL run_enable_held: got gap in cpu_en expected %0d enabled cycles", n + 1);
    end
    total++;
    if ({cpu_en_a, done_a, busy_a} !== 3'b010) begin
      bad++; $display("FAIL run_halt_state: got en/done/busy=%b expected 010", {cpu_en_a, done_a, busy_a});
    end
    total++;
    if (count_a !== 16'(exp_count)) begin
      bad++; $display("FAIL run_count: got %0d expected %0d", count_a, exp_count);
    end
    instr = nonhalt();
    send_cmd(RUN);
    @(negedge clk);
    total++;
    if ({cpu_en_a, done_a, count_a} !== {2'b01, 16'(exp_count)}) begin
      bad++; $display("FAIL run_ignored_in_done: got en=%b done=%b count=%0d expected en=0 done=1 count=%0d",
        cpu_en_a, done_a, count_a, exp_count);
    end
  endtask

  task automatic test_abort();
    int c0 = clr_cnt;
    wlog_a.delete();
    send_cmd(LOAD);
    exp_count = 0;
    send_byte(8'($urandom));
    send_cmd(ABORT);
    total++;
    if ({imem_sel_a, byte_ready_a, busy_a, cpu_en_a} !== 4'b0) begin
      bad++; $display("FAIL abort_one_byte: got sel/rdy/busy/en=%b expected 0000",
        {imem_sel_a, byte_ready_a, busy_a, cpu_en_a});
    end
    send_cmd(LOAD);
    send_byte(8'h48);
    cmd_valid = 1'b1; cmd = ABORT; byte_valid = 1'b1; bdata = 8'h5a;
    @(negedge clk);
    cmd_valid = 1'b0; byte_valid = 1'b0;
    total++;
    if ({busy_a, imem_we_a, imem_sel_a} !== 3'b0) begin
      bad++; $display("FAIL abort_with_byte: got busy/we/sel=%b expected 000", {busy_a, imem_we_a, imem_sel_a});
    end
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (wlog_a.size() != 0) begin
      bad++; $display("FAIL abort_no_write: got %0d writes expected 0", wlog_a.size());
    end
    total++;
    if (clr_cnt - c0 != 2 || count_a !== 16'd0) begin
      bad++; $display("FAIL abort_clr_count: got clr=%0d count=%0d expected clr=2 count=0", clr_cnt - c0, count_a);
    end
    prog = {8'h00, 8'h00};
    model_load(2047);
    load_program();
    total++;
    if (wlog_a.size() != 1 || wlog_a[0] !== exp_w[0]) begin
      bad++; $display("FAIL abort_reload_write: got %0d writes first=%h expected 1 write %h",
        wlog_a.size(), (wlog_a.size() > 0) ? wlog_a[0] : 32'hffff_ffff, exp_w[0]);
    end
  endtask

  task automatic test_step();
    for (int i = 0; i < 3; i++) begin
      instr = nonhalt();
      send_cmd(STEP);
      total++;
      if (cpu_en_a !== 1'b1) begin
        bad++; $display("FAIL step%0d_enable: got %b expected 1", i, cpu_en_a);
      end
      @(negedge clk);
      exp_count++;
      total++;
      if ({cpu_en_a, busy_a, done_a} !== 3'b000) begin
        bad++; $display("FAIL step%0d_idle: got en/busy/done=%b expected 000", i, {cpu_en_a, busy_a, done_a});
      end
    end
    total++;
    if (count_a !== 16'(exp_count)) begin
      bad++; $display("FAIL step_count: got %0d expected %0d", count_a, exp_count);
    end
    instr = halt_word();
    send_cmd(STEP);
    @(negedge clk);
    exp_count++;
    total++;
    if ({cpu_en_a, done_a, count_a} !== {2'b01, 16'(exp_count)}) begin
      bad++; $display("FAIL step_halt: got en=%b done=%b count=%0d expected en=0 done=1 count=%0d",
        cpu_en_a, done_a, count_a, exp_count);
    end
    instr = nonhalt();
    send_cmd(STEP);
    total++;
    if ({cpu_en_a, done_a, count_a} !== {2'b01, 16'(exp_count)}) begin
      bad++; $display("FAIL step_ignored_in_done: got en=%b done=%b count=%0d expected en=0 done=1 count=%0d",
        cpu_en_a, done_a, count_a, exp_count);
    end
  endtask

  task automatic test_run_abort();
    int j = $urandom_range(2, 10);
    int c0;
    send_cmd(ABORT);
    instr = nonhalt();
    send_cmd(RUN);
    repeat (j) @(negedge clk);
    c0 = clr_cnt;
    send_cmd(LOAD);
    total++;
    if ({imem_sel_a, cpu_en_a, busy_a} !== 3'b011) begin
      bad++; $display("FAIL run_load_dropped: got sel/en/busy=%b expected 011", {imem_sel_a, cpu_en_a, busy_a});
    end
    send_cmd(ABORT);
    exp_count += j + 2;
    #1;
    total++;
    if ({cpu_en_a, busy_a, done_a, imem_sel_a} !== 4'b0 || clr_cnt != c0) begin
      bad++; $display("FAIL run_abort_state: got en/busy/done/sel=%b clr=%0d expected 0000 clr=0",
        {cpu_en_a, busy_a, done_a, imem_sel_a}, clr_cnt - c0);
    end
    total++;
    if (count_a !== 16'(exp_count)) begin
      bad++; $display("FAIL run_abort_count: got %0d expected %0d", count_a, exp_count);
    end
  endtask

  task automatic test_reset_mid_run();
    instr = nonhalt();
    send_cmd(RUN);
    total++;
    if (cpu_en_a !== 1'b1) begin
      bad++; $display("FAIL midrun_enable: got %b expected 1", cpu_en_a);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cmd_ready_a, byte_ready_a, cpu_en_a, cpu_clr_a, imem_sel_a, imem_we_a, busy_a, done_a} !== 8'b1000_0000
        || count_a !== 16'd0 || imem_addr_a !== 11'd0) begin
      bad++; $display("FAIL midrun_async_reset: got flags=%b count=%0d expected 10000000 count=0",
        {cmd_ready_a, byte_ready_a, cpu_en_a, cpu_clr_a, imem_sel_a, imem_we_a, busy_a, done_a}, count_a);
    end
    #1 rst_n = 1'b1;
    exp_count = 0;
    @(negedge clk);
    total++;
    if ({cpu_en_a, busy_a, done_a, count_a} !== 19'd0) begin
      bad++; $display("FAIL midrun_after_release: got en/busy/done=%b count=%0d expected idle count=0",
        {cpu_en_a, busy_a, done_a}, count_a);
    end
  endtask

  task automatic test_addr_wrap();
    logic [15:0] w;
    prog.delete();
    repeat (5) begin
      w = nonhalt();
      prog.push_back(w[15:8]);
      prog.push_back(w[7:0]);
    end
    wlog_a.delete();
    wlog_b.delete();
    send_cmd(LOAD);
    for (int i = 0; i < 8; i++) send_byte(prog[i]);
    @(negedge clk);
    total++;
    if ({byte_ready_b, busy_b, imem_sel_b, imem_addr_b, byte_ready_a} !== 6'b000_11_1) begin
      bad++; $display("FAIL wrap_stop: got rdyB/busyB/selB/addrB/rdyA=%b expected 000111",
        {byte_ready_b, busy_b, imem_sel_b, imem_addr_b, byte_ready_a});
    end
    for (int i = 8; i < 10; i++) begin
      send_byte(prog[i]);
      total++;
      if (byte_ready_b !== 1'b0) begin
        bad++; $display("FAIL wrap_byte%0d_ready: got %b expected 0", i, byte_ready_b);
      end
    end
    repeat (2) @(negedge clk);
    #1;
    model_load(3);
    total++;
    if (wlog_b.size() != exp_w.size()) begin
      bad++; $display("FAIL wrap_write_count: got %0d expected %0d", wlog_b.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < wlog_b.size(); i++) begin
      total++;
      if (wlog_b[i] !== exp_w[i]) begin
        bad++; $display("FAIL wrap_write[%0d]: got %h expected %h", i, wlog_b[i], exp_w[i]);
      end
    end
    model_load(2047);
    total++;
    if (wlog_a.size() != exp_w.size()) begin
      bad++; $display("FAIL wide_write_count: got %0d expected %0d", wlog_a.size(), exp_w.size());
    end
    send_cmd(ABORT);
  endtask

  initial begin
    test_reset();
    test_load();
    test_run(7);
    test_run($urandom_range(3, 12));
    test_abort();
    test_step();
    test_run_abort();
    test_reset_mid_run();
    test_addr_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
